instr_fetch_stage: RTL and testbench

//  Fetch stage for the MIPS core; sits directly upstream of the control/decode stage.

---
 rtl/mips_pkg.sv | 18 +
 rtl/if_skid_fifo.sv | 45 ++++
 rtl/instr_fetch_stage.sv | 145 ++++++++++++++
 tb/tb_instr_fetch_stage.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: datapath width, reset PC, primary opcodes, fetch FSM states.
package mips_pkg;

  localparam int          DATA_WIDTH = 32;
  localparam logic [31:0] PC_RESET   = 32'h0040_0000;

  localparam logic [5:0] R_TYPE = 6'h00;
  localparam logic [5:0] ADDI   = 6'h08;
  localparam logic [5:0] ORI    = 6'h0d;
  localparam logic [5:0] LUI    = 6'h0f;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_skid_fifo.sv
// Two-entry {instr, pc} buffer between instruction memory and decode; flush empties it in one cycle.
module if_skid_fifo #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_push_instr,
  input  logic [W-1:0] i_push_pc,
  input  logic         i_pop,
  input  logic         i_flush,
  output logic [1:0]   o_count,
  output logic [W-1:0] o_head_instr,
  output logic [W-1:0] o_head_pc
);

  logic [2*W-1:0] r_mem [2];
  logic           r_wr_ptr;
  logic           r_rd_ptr;
  logic [1:0]     r_count;

  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= {i_push_instr, i_push_pc};
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (i_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  assign o_count = r_count;
  assign {o_head_instr, o_head_pc} = r_mem[r_rd_ptr];

  a_no_overflow: assert property (@(posedge clk) disable iff (reset || i_flush)
    !(i_push && !i_pop && r_count == 2'd2));
  a_no_underflow: assert property (@(posedge clk) disable iff (reset || i_flush)
    !(i_pop && r_count == 2'd0));

endmodule

// File: rtl/instr_fetch_stage.sv
// MIPS fetch stage: PC, credit-limited in-order imem reads, 2-deep buffer, redirect with stale discard.
// Optional IF_PERF_CNT_EN adds perf_fetched / perf_flushed counters.
module instr_fetch_stage #(
  parameter int                    DATA_WIDTH = mips_pkg::DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] PC_RESET   = mips_pkg::PC_RESET
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  id_valid,
  input  logic                  id_ready,
  output logic [DATA_WIDTH-1:0] id_instr,
  output logic [DATA_WIDTH-1:0] id_pc,
  output logic [DATA_WIDTH-1:0] id_pc_plus4,
  output logic [5:0]            id_opcode,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]           perf_fetched,
  output logic [31:0]           perf_flushed,
`endif
  output logic [1:0]            dbg_state
);

  import mips_pkg::*;

  // Handshakes: imem transfer on req&gnt (addr stable while req), decode pop on id_valid&id_ready;
  // id_valid never depends on id_ready, imem_req never depends on imem_gnt.

  fetch_state_e          r_state, w_state_next;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [1:0]            r_live_cnt;
  logic [1:0]            r_discard_cnt;
  logic [DATA_WIDTH-1:0] r_ifq [2];
  logic                  r_ifq_wr, r_ifq_rd;

  logic [1:0]            w_fifo_count;
  logic [DATA_WIDTH-1:0] w_head_instr, w_head_pc;
  logic [1:0]            w_stale, w_stale_left, w_credit;
  logic                  w_drop, w_live_rsp, w_accept, w_pop;

  // Outstanding reads never exceed two, so 2-bit sums cannot overflow.
  assign w_stale      = r_discard_cnt + r_live_cnt;
  assign w_drop       = imem_rvalid && (r_discard_cnt != 2'd0 || (redirect_valid && r_live_cnt != 2'd0));
  assign w_stale_left = w_stale - {1'b0, w_drop};
  assign w_live_rsp   = imem_rvalid && !redirect_valid && r_discard_cnt == 2'd0 && r_live_cnt != 2'd0;
  assign w_credit     = w_fifo_count + r_live_cnt;
  assign w_accept     = imem_req && imem_gnt;
  assign w_pop        = id_valid && id_ready && !redirect_valid;

  always_comb begin
    w_state_next = r_state;
    imem_req     = 1'b0;
    case (r_state)
      IDLE: w_state_next = RUN;
      RUN: begin
        if (redirect_valid) begin
          if (w_stale_left != 2'd0) w_state_next = FLUSH;
        end else begin
          imem_req = (r_discard_cnt == 2'd0) && (w_credit < 2'd2);
        end
      end
      FLUSH: if (!redirect_valid && r_discard_cnt == 2'd0) w_state_next = RUN;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_pc          <= PC_RESET;
      r_live_cnt    <= 2'd0;
      r_discard_cnt <= 2'd0;
      r_ifq_wr      <= 1'b0;
      r_ifq_rd      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (redirect_valid) begin
        // Every read still in flight becomes stale; the one returning right now is already dropped.
        r_pc          <= redirect_pc & {{(DATA_WIDTH-2){1'b1}}, 2'b00};
        r_live_cnt    <= 2'd0;
        r_discard_cnt <= w_stale_left;
        r_ifq_wr      <= 1'b0;
        r_ifq_rd      <= 1'b0;
      end else begin
        if (w_accept) begin
          r_pc            <= r_pc + {{(DATA_WIDTH-3){1'b0}}, 3'd4};
          r_ifq[r_ifq_wr] <= r_pc;
          r_ifq_wr        <= ~r_ifq_wr;
        end
        if (w_live_rsp) r_ifq_rd <= ~r_ifq_rd;
        if (w_drop) r_discard_cnt <= r_discard_cnt - 2'd1;
        r_live_cnt <= r_live_cnt + {1'b0, w_accept} - {1'b0, w_live_rsp};
      end
    end
  end

  if_skid_fifo #(.W(DATA_WIDTH)) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .i_push       (w_live_rsp),
    .i_push_instr (imem_rdata),
    .i_push_pc    (r_ifq[r_ifq_rd]),
    .i_pop        (w_pop),
    .i_flush      (redirect_valid),
    .o_count      (w_fifo_count),
    .o_head_instr (w_head_instr),
    .o_head_pc    (w_head_pc)
  );

  assign imem_addr   = r_pc;
  assign id_valid    = w_fifo_count != 2'd0;
  assign id_instr    = id_valid ? w_head_instr : '0;
  assign id_pc       = id_valid ? w_head_pc : '0;
  assign id_pc_plus4 = id_pc + {{(DATA_WIDTH-3){1'b0}}, 3'd4};
  assign id_opcode   = id_instr[DATA_WIDTH-1 -: 6];
  assign dbg_state   = r_state;

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_perf_fetched, r_perf_flushed;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_fetched <= 32'd0;
      r_perf_flushed <= 32'd0;
    end else begin
      if (w_pop) r_perf_fetched <= r_perf_fetched + 32'd1;
      r_perf_flushed <= r_perf_flushed
                      + (redirect_valid ? {30'd0, w_fifo_count} : 32'd0)
                      + {31'd0, w_drop};
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_flushed = r_perf_flushed;
`endif

  a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (reset)
    imem_rvalid |-> (r_live_cnt != 2'd0 || r_discard_cnt != 2'd0));

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: reset/stream vector table, directed stall/redirect/wrap sequences,
// then randomized traffic checked against a program-order scoreboard.
module tb_instr_fetch_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid, id_ready = 1'b0;
  logic [31:0] id_instr, id_pc, id_pc_plus4;
  logic [5:0]  id_opcode;
  logic [1:0]  dbg_state;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_flushed;
`endif

  always #5 clk = ~clk;

  instr_fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4),
    .id_opcode      (id_opcode),
`ifdef IF_PERF_CNT_EN
    .perf_fetched   (perf_fetched),
    .perf_flushed   (perf_flushed),
`endif
    .dbg_state      (dbg_state)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rsp_t;

  typedef struct {
    logic         rst;
    logic         chk;
    logic         exp_req;
    logic [31:0]  exp_addr;
    logic         exp_valid;
    logic [31:0]  exp_pc;
    fetch_state_e exp_state;
  } vec_t;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          last_due = -1;
  logic [31:0] exp_q[$];
  rsp_t        resp_q[$];
  logic [31:0] pc_log[$];
  logic [31:0] p4_log[$];
  logic [31:0] model_pc = PC_RESET;
  int          model_pops = 0;
  int          model_flushed = 0;

  logic        drv_reset = 1'b1, drv_gnt = 1'b1, drv_ready = 1'b1, drv_redir = 1'b0;
  logic [31:0] drv_target = '0;
  int          drv_lat = 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, sample and model before the rising edge.
  task automatic tick();
    logic [31:0] e, w;
    int          due;
    @(negedge clk);
    reset          = drv_reset;
    imem_gnt       = drv_gnt;
    id_ready       = drv_ready;
    redirect_valid = drv_redir;
    redirect_pc    = drv_target;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    if (!drv_reset && resp_q.size() > 0 && resp_q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(resp_q[0].addr);
      resp_q.delete(0);
    end
    #1;
    if (drv_reset) begin
      exp_q.delete();
      resp_q.delete();
      model_pc      = PC_RESET;
      last_due      = -1;
      model_pops    = 0;
      model_flushed = 0;
    end else begin
      if (!id_valid) begin
        chk("idle_instr_zero", id_instr, 32'd0);
        chk("idle_pc_zero", id_pc, 32'd0);
      end
      if (redirect_valid) begin
        chk("redirect_no_req", {31'd0, imem_req}, 32'd0);
        model_flushed += exp_q.size();
        exp_q.delete();
        model_pc = drv_target & 32'hFFFF_FFFC;
      end else begin
        if (imem_req) chk("imem_addr", imem_addr, model_pc);
        if (id_valid && id_ready) begin
          if (exp_q.size() == 0) begin
            chk("pop_unexpected", {31'd0, id_valid}, 32'd0);
          end else begin
            e = exp_q.pop_front();
            w = mem_word(e);
            chk("pop_pc", id_pc, e);
            chk("pop_instr", id_instr, w);
            chk("pop_pc_plus4", id_pc_plus4, e + 32'd4);
            chk("pop_opcode", {26'd0, id_opcode}, {26'd0, w[31:26]});
          end
          model_pops++;
          pc_log.push_back(id_pc);
          p4_log.push_back(id_pc_plus4);
        end
        if (imem_req && imem_gnt) begin
          exp_q.push_back(model_pc);
          due = cyc + drv_lat;
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          resp_q.push_back('{imem_addr, due});
          model_pc += 32'd4;
        end
      end
    end
    drv_redir = 1'b0;
    cyc++;
  endtask

  task automatic drain();
    int n;
    n = 0;
    drv_gnt   = 1'b0;
    drv_ready = 1'b1;
    while ((exp_q.size() != 0 || resp_q.size() != 0) && n < 80) begin
      tick();
      n++;
    end
    chk("drain_complete", 32'(exp_q.size() + resp_q.size()), 32'd0);
    repeat (3) tick();
  endtask

  function automatic vec_t mk(input logic rst, input logic c, input logic rq, input logic [31:0] a,
                              input logic v, input logic [31:0] p, input fetch_state_e s);
    vec_t r;
    r.rst = rst; r.chk = c; r.exp_req = rq; r.exp_addr = a;
    r.exp_valid = v; r.exp_pc = p; r.exp_state = s;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[12];
    int   n;

    // gnt=1, ready=1, 1-cycle latency; credit fifo+in-flight<2 gives two words every three cycles.
    vecs[0]  = mk(1, 0, 0, 0,            0, 0,            IDLE);
    vecs[1]  = mk(1, 1, 0, 0,            0, 0,            IDLE);
    vecs[2]  = mk(1, 1, 0, 0,            0, 0,            IDLE);
    vecs[3]  = mk(0, 1, 0, 0,            0, 0,            IDLE);
    vecs[4]  = mk(0, 1, 1, 32'h00400000, 0, 0,            RUN);
    vecs[5]  = mk(0, 1, 1, 32'h00400004, 0, 0,            RUN);
    vecs[6]  = mk(0, 1, 0, 0,            1, 32'h00400000, RUN);
    vecs[7]  = mk(0, 1, 1, 32'h00400008, 1, 32'h00400004, RUN);
    vecs[8]  = mk(0, 1, 1, 32'h0040000C, 0, 0,            RUN);
    vecs[9]  = mk(0, 1, 0, 0,            1, 32'h00400008, RUN);
    vecs[10] = mk(0, 1, 1, 32'h00400010, 1, 32'h0040000C, RUN);
    vecs[11] = mk(0, 1, 1, 32'h00400014, 0, 0,            RUN);

    drv_gnt = 1'b1; drv_ready = 1'b1; drv_lat = 1;
    for (int i = 0; i < 12; i++) begin
      drv_reset = vecs[i].rst;
      tick();
      if (vecs[i].chk) begin
        chk($sformatf("v%0d_req", i), {31'd0, imem_req}, {31'd0, vecs[i].exp_req});
        if (vecs[i].exp_req) chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].exp_addr);
        chk($sformatf("v%0d_valid", i), {31'd0, id_valid}, {31'd0, vecs[i].exp_valid});
        if (vecs[i].exp_valid) chk($sformatf("v%0d_pc", i), id_pc, vecs[i].exp_pc);
        chk($sformatf("v%0d_state", i), 32'(dbg_state), 32'(vecs[i].exp_state));
      end
    end

    // Decode stalls for 6 cycles: buffer fills to two and requests stop.
    drv_ready = 1'b0;
    repeat (6) tick();
    chk("stall_req_low", {31'd0, imem_req}, 32'd0);
    chk("stall_valid", {31'd0, id_valid}, 32'd1);
    chk("stall_head_pc", id_pc, 32'h00400010);
    drv_ready = 1'b1;
    repeat (8) tick();
    drain();

    // Two reads in flight with latency 3, then redirect to an unaligned target.
    drv_lat = 3; drv_gnt = 1'b1;
    tick();
    tick();
    drv_gnt = 1'b0; drv_redir = 1'b1; drv_target = 32'h00400103;
    chk("t4_two_stale", 32'(exp_q.size()), 32'd2);
    tick();
    tick();
    chk("t4_state_flush", 32'(dbg_state), 32'(FLUSH));
    chk("t4_valid_low", {31'd0, id_valid}, 32'd0);
    n = 0;
    while (n < 10) begin
      tick();
      n++;
      if (imem_req) break;
    end
    chk("t4_flush_cycles", 32'(n), 32'd3);
    chk("t4_redirect_addr", imem_addr, 32'h00400100);
    chk("t4_state_run", 32'(dbg_state), 32'(RUN));
`ifdef IF_PERF_CNT_EN
    chk("t4_perf_flushed", perf_flushed, 32'(model_flushed));
    chk("t4_perf_fetched", perf_fetched, 32'(model_pops));
`endif

    // Redirect to the top word with nothing in flight; the fetch wraps to zero.
    drv_redir = 1'b1; drv_target = 32'hFFFF_FFFC;
    tick();
    tick();
    chk("t5_state_run", 32'(dbg_state), 32'(RUN));
    chk("t5_addr", imem_addr, 32'hFFFF_FFFC);
    pc_log.delete(); p4_log.delete();
    drv_gnt = 1'b1; drv_lat = 1; drv_ready = 1'b1;
    n = 0;
    while (pc_log.size() < 2 && n < 20) begin
      tick();
      n++;
    end
    chk("t5_pops", {31'd0, pc_log.size() >= 2}, 32'd1);
    if (pc_log.size() >= 2) begin
      chk("t5_first_pc", pc_log[0], 32'hFFFF_FFFC);
      chk("t5_first_plus4", p4_log[0], 32'h0000_0000);
      chk("t5_second_pc", pc_log[1], 32'h0000_0000);
    end
    drain();

    // Randomized traffic: grant, ready, latency and redirects all vary.
    drv_redir = 1'b1; drv_target = PC_RESET;
    tick();
    for (int i = 0; i < 500; i++) begin
      drv_gnt   = $urandom_range(0, 3) != 0;
      drv_ready = $urandom_range(0, 3) != 0;
      drv_lat   = $urandom_range(1, 3);
      if ($urandom_range(0, 24) == 0) begin
        drv_redir  = 1'b1;
        drv_target = 32'h00400000 + 32'($urandom_range(0, 1023)) * 32'd4 + 32'($urandom_range(0, 3));
      end
      tick();
    end
    drain();
    chk("final_pops_nonzero", {31'd0, model_pops > 50}, 32'd1);
`ifdef IF_PERF_CNT_EN
    chk("final_perf_fetched", perf_fetched, 32'(model_pops));
    chk("final_perf_flushed", perf_flushed, 32'(model_flushed));
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
